// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock divider / tick generator. Divisor changes are
// deferred to period boundaries (or applied while frozen/cleared) so divided_clk never glitches.
module prog_clk_divider #(
  parameter int unsigned          CNT_W       = 21,
  parameter logic [CNT_W-1:0]     DEFAULT_DIV = CNT_W'(21'h1FFFFF)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             divided_clk,
  output logic             tick,
  output logic [CNT_W-1:0] active_div,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dclk_q, dclk_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] active_div_q, active_div_d;
  logic [CNT_W-1:0] pending_div_q, pending_div_d;
  logic             pending_q, pending_d;

  logic             boundary;
  logic             apply_new;
  logic [CNT_W-1:0] new_div;

  // A same-cycle load always overrides a previously parked divisor.
  function automatic logic [CNT_W-1:0] select_div(input logic             load,
                                                  input logic [CNT_W-1:0] val,
                                                  input logic [CNT_W-1:0] parked);
    return load ? val : parked;
  endfunction

  assign boundary  = en && !sync_clr && (cnt_q == active_div_q);
  assign apply_new = div_load || pending_q;
  assign new_div   = select_div(div_load, div_val, pending_div_q);

  always_comb begin
    cnt_d         = cnt_q;
    dclk_d        = dclk_q;
    tick_d        = 1'b0;
    active_div_d  = active_div_q;
    pending_div_d = pending_div_q;
    pending_d     = pending_q;

    if (sync_clr) begin
      cnt_d  = '0;
      dclk_d = 1'b0;
      if (apply_new) begin
        active_div_d = new_div;
        pending_d    = 1'b0;
      end
    end else if (en) begin
      if (boundary) begin
        cnt_d  = '0;
        dclk_d = ~dclk_q;
        tick_d = 1'b1;
        if (apply_new) begin
          active_div_d = new_div;
          pending_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        // Mid-period loads are parked; the last one before the boundary wins.
        if (div_load) begin
          pending_div_d = div_val;
          pending_d     = 1'b1;
        end
      end
    end else begin
      // Output frozen: safe to switch divisor and restart the phase now.
      if (apply_new) begin
        active_div_d = new_div;
        pending_d    = 1'b0;
        cnt_d        = '0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      dclk_q        <= 1'b0;
      tick_q        <= 1'b0;
      active_div_q  <= DEFAULT_DIV;
      pending_div_q <= '0;
      pending_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dclk_q        <= dclk_d;
      tick_q        <= tick_d;
      active_div_q  <= active_div_d;
      pending_div_q <= pending_div_d;
      pending_q     <= pending_d;
    end
  end

  assign divided_clk = dclk_q;
  assign tick        = tick_q;
  assign active_div  = active_div_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider (CNT_W=8, DEFAULT_DIV=3); outputs are
// sampled 1 time unit after each rising clk_in edge.
module tb_prog_clk_divider;

  logic       clk_in;
  logic       rst;
  logic       en;
  logic       sync_clr;
  logic [7:0] div_val;
  logic       div_load;
  logic       divided_clk;
  logic       tick;
  logic [7:0] active_div;
  logic       pending;

  int total = 0;
  int bad   = 0;

  prog_clk_divider #(.CNT_W(8), .DEFAULT_DIV(8'd3)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .sync_clr    (sync_clr),
    .div_val     (div_val),
    .div_load    (div_load),
    .divided_clk (divided_clk),
    .tick        (tick),
    .active_div  (active_div),
    .pending     (pending)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic outs(input string tag, input logic d, input logic t);
    chk({tag, ".dclk"}, {31'd0, divided_clk}, {31'd0, d});
    chk({tag, ".tick"}, {31'd0, tick}, {31'd0, t});
  endtask

  task automatic divst(input string tag, input logic [7:0] a, input logic p);
    chk({tag, ".active"}, {24'd0, active_div}, {24'd0, a});
    chk({tag, ".pending"}, {31'd0, pending}, {31'd0, p});
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; sync_clr = 1'b0; div_val = 8'd0; div_load = 1'b0;
    #2 rst = 1'b1;
    #1;
    outs("rst_async", 1'b0, 1'b0);
    divst("rst_async", 8'd3, 1'b0);
    step(2);
    rst = 1'b0;

    // Default divisor 3: toggle every 4 edges.
    step(3); outs("def_e3", 1'b0, 1'b0);
    step(1); outs("def_e4", 1'b1, 1'b1); divst("def_e4", 8'd3, 1'b0);
    step(1); outs("def_e5", 1'b1, 1'b0);
    step(3); outs("def_e8", 1'b0, 1'b1);

    // Mid-period load of 9 waits for the boundary.
    step(1);
    div_load = 1'b1; div_val = 8'd9;
    step(1);
    div_load = 1'b0;
    divst("ld9_parked", 8'd3, 1'b1);
    step(1); outs("ld9_e11", 1'b0, 1'b0);
    step(1); outs("ld9_e12", 1'b1, 1'b1); divst("ld9_applied", 8'd9, 1'b0);
    step(9); outs("div9_e21", 1'b1, 1'b0);
    step(1); outs("div9_e22", 1'b0, 1'b1);

    // Loads 5 then 7 before a boundary: 7 wins.
    div_load = 1'b1; div_val = 8'd5;
    step(1);
    div_val = 8'd7;
    step(1);
    div_load = 1'b0;
    divst("ld57_parked", 8'd9, 1'b1);
    step(8); outs("ld57_bnd", 1'b1, 1'b1); divst("ld57_applied", 8'd7, 1'b0);

    // Load 2 in the boundary cycle itself.
    step(7); outs("div7_pre", 1'b1, 1'b0);
    div_load = 1'b1; div_val = 8'd2;
    step(1);
    div_load = 1'b0;
    outs("ld2_bnd", 1'b0, 1'b1); divst("ld2_bnd", 8'd2, 1'b0);
    step(2); outs("div2_e2", 1'b0, 1'b0);
    step(1); outs("div2_e3", 1'b1, 1'b1);

    // Freeze at cnt=2 for 20 cycles.
    step(2);
    en = 1'b0;
    step(1); outs("frz_1", 1'b1, 1'b0);
    step(19); outs("frz_20", 1'b1, 1'b0);
    div_load = 1'b1; div_val = 8'd6;
    step(1);
    div_load = 1'b0; en = 1'b1;
    outs("frz_ld6", 1'b1, 1'b0); divst("frz_ld6", 8'd6, 1'b0);
    step(6); outs("div6_e6", 1'b1, 1'b0);
    step(1); outs("div6_e7", 1'b0, 1'b1);

    // Divisor 0: clk_in/2, tick continuously high.
    div_load = 1'b1; div_val = 8'd0;
    step(1);
    div_load = 1'b0;
    divst("ld0_parked", 8'd6, 1'b1);
    step(6); outs("div0_a", 1'b1, 1'b1); divst("div0", 8'd0, 1'b0);
    step(1); outs("div0_b", 1'b0, 1'b1);
    step(1); outs("div0_c", 1'b1, 1'b1);
    sync_clr = 1'b1;
    step(1); outs("sclr", 1'b0, 1'b0);
    sync_clr = 1'b0;
    step(1); outs("sclr_resume", 1'b1, 1'b1);

    // Build up a pending load with divided_clk high, then reset mid-period.
    div_load = 1'b1; div_val = 8'd5;
    step(1);
    div_load = 1'b0;
    outs("ld5_bnd", 1'b0, 1'b1); divst("ld5_bnd", 8'd5, 1'b0);
    step(6); outs("div5_bnd", 1'b1, 1'b1);
    div_load = 1'b1; div_val = 8'd8;
    step(1);
    div_load = 1'b0;
    outs("pre_rst", 1'b1, 1'b0); divst("pre_rst", 8'd5, 1'b1);
    #3 rst = 1'b1;
    #1;
    outs("rst_mid", 1'b0, 1'b0); divst("rst_mid", 8'd3, 1'b0);
    step(1);
    rst = 1'b0;

    // sync_clr applies a pending divisor immediately.
    step(1);
    div_load = 1'b1; div_val = 8'd10;
    step(1);
    div_load = 1'b0;
    divst("sclr_pend_pre", 8'd3, 1'b1);
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    outs("sclr_pend", 1'b0, 1'b0); divst("sclr_pend", 8'd10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
